bg_rom_arbiter: RTL and testbench

//  Shares one synchronous background/sprite colour ROM port between N_REQ requesters.

---
 rtl/bg_rom_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bg_rom_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter
// Shares one colour ROM read port between N_REQ requesters. Port 0 (VGA pixel
// fetch) has fixed top priority. Ports 1..N_REQ-1 share the remaining slots
// round-robin. A low-priority port that has waited MAX_WAIT cycles overrides
// port 0 for one grant. Responses come back in accept order, tagged by a
// one-hot rsp_valid, 1+ROM_LAT cycles after the accept.
module bg_rom_arbiter #(
    parameter int N_REQ    = 3,
    parameter int AW       = 17,
    parameter int DW       = 24,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    output logic [N_REQ-1:0]      req_ready,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_data,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic [N_REQ-1:0]      starve
);

    localparam int              WW      = $clog2(MAX_WAIT + 1);
    localparam int              PW      = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam logic [WW-1:0]   LP_MAX  = WW'(MAX_WAIT);
    localparam logic [PW-1:0]   LP_LAST = PW'(N_REQ - 1);
    localparam logic [PW-1:0]   LP_ONE  = PW'(1);
    localparam logic [PW-1:0]   LP_ZERO = PW'(0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WW-1:0]      r_wait [N_REQ];
    logic [PW-1:0]      r_rr_ptr;
    logic [AW-1:0]      r_rom_addr;
    logic [N_REQ-1:0]   r_tag  [ROM_LAT+1];
    logic [DW-1:0]      r_rsp_data;
    logic [N_REQ-1:0]   r_starve;

    // ------------------------------------------------------------------
    // Combinational arbitration signals
    // ------------------------------------------------------------------
    logic               w_ovr_hit;
    logic [PW-1:0]      w_ovr_idx;
    logic               w_rr_hit;
    logic [PW-1:0]      w_rr_idx;
    int                 w_rr_k;
    logic               w_gnt_any;
    logic [PW-1:0]      w_gnt_idx;
    logic [N_REQ-1:0]   w_grant;
    logic [AW-1:0]      w_gnt_addr;
    logic [PW-1:0]      w_rr_ptr_nxt;
    logic [WW-1:0]      w_wait_nxt [N_REQ];

    // Starvation override: lowest-index low-priority port sitting at MAX_WAIT.
    always_comb begin
        w_ovr_hit = 1'b0;
        w_ovr_idx = LP_ZERO;
        // Scan downward so the lowest matching index is the last one written.
        for (int i = N_REQ - 1; i >= 1; i--) begin
            if (req_valid[i] && (r_wait[i] == LP_MAX)) begin
                w_ovr_hit = 1'b1;
                w_ovr_idx = PW'(i);
            end else begin
                w_ovr_hit = w_ovr_hit;
            end
        end
    end

    // Round-robin pick among ports 1..N_REQ-1, starting at the RR pointer.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = LP_ZERO;
        w_rr_k   = 0;
        for (int off = 0; off < N_REQ - 1; off++) begin
            // Wrap from N_REQ-1 back to 1; port 0 never takes part here.
            w_rr_k = int'(r_rr_ptr) + off;
            if (w_rr_k > N_REQ - 1) begin
                w_rr_k = w_rr_k - (N_REQ - 1);
            end else begin
                w_rr_k = w_rr_k;
            end
            if (!w_rr_hit && req_valid[PW'(w_rr_k)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = PW'(w_rr_k);
            end else begin
                w_rr_hit = w_rr_hit;
            end
        end
    end

    // Final grant: override, then port 0, then round-robin, else nothing.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = LP_ZERO;
        if (w_ovr_hit) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_ovr_idx;
        end else if (req_valid[0]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = LP_ZERO;
        end else if (w_rr_hit) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt_any = 1'b0;
            w_gnt_idx = LP_ZERO;
        end
        w_grant = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : N_REQ'(0);
    end

    assign w_gnt_addr = req_addr[int'(w_gnt_idx) * AW +: AW];
    assign req_ready  = w_grant;

    // Next RR pointer and per-port wait counters.
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        // Only low-priority grants move the pointer; port 0 grants leave it alone.
        if (w_gnt_any && (w_gnt_idx != LP_ZERO)) begin
            w_rr_ptr_nxt = (w_gnt_idx == LP_LAST) ? LP_ONE : (w_gnt_idx + LP_ONE);
        end else begin
            w_rr_ptr_nxt = r_rr_ptr;
        end
        for (int i = 0; i < N_REQ; i++) begin
            w_wait_nxt[i] = WW'(0);
        end
        for (int i = 1; i < N_REQ; i++) begin
            // A grant or a dropped request restarts the count, so the same
            // port can never override on two consecutive cycles.
            if (!req_valid[i] || w_grant[i]) begin
                w_wait_nxt[i] = WW'(0);
            end else if (r_wait[i] != LP_MAX) begin
                w_wait_nxt[i] = r_wait[i] + WW'(1);
            end else begin
                w_wait_nxt[i] = r_wait[i];
            end
        end
    end

    // ROM address register: load the granted address, otherwise hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= AW'(0);
        end else if (w_gnt_any) begin
            r_rom_addr <= w_gnt_addr;
        end else begin
            r_rom_addr <= r_rom_addr;
        end
    end

    // Tag pipeline tracking which port owns each in-flight read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s <= ROM_LAT; s++) begin
                r_tag[s] <= N_REQ'(0);
            end
        end else begin
            r_tag[0] <= w_grant & req_valid;
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Response data: capture ROM output as its tag reaches the pipe output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rsp_data <= DW'(0);
        end else if (|r_tag[ROM_LAT-1]) begin
            r_rsp_data <= rom_data;
        end else begin
            r_rsp_data <= r_rsp_data;
        end
    end

    // Arbitration state: RR pointer, wait counters and registered starve flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr_ptr <= LP_ONE;
            r_starve <= N_REQ'(0);
            for (int i = 0; i < N_REQ; i++) begin
                r_wait[i] <= WW'(0);
            end
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_starve[0] <= 1'b0;
            for (int i = 1; i < N_REQ; i++) begin
                r_starve[i] <= (w_wait_nxt[i] == LP_MAX);
            end
            for (int i = 0; i < N_REQ; i++) begin
                r_wait[i] <= w_wait_nxt[i];
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_tag[ROM_LAT];
    assign rsp_data  = r_rsp_data;
    assign starve    = r_starve;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// tb_bg_rom_arbiter
// Directed and random stimulus for bg_rom_arbiter. A transaction-level model
// (priority rules, wait counts, queue of outstanding reads) predicts grants,
// starve flags and responses every cycle; directed sections also compare
// against hand-computed literals.
module tb_bg_rom_arbiter;

    localparam int N_REQ    = 3;
    localparam int AW       = 17;
    localparam int DW       = 24;
    localparam int ROM_LAT  = 1;
    localparam int MAX_WAIT = 15;

    logic                  Clk = 1'b0;
    logic                  Reset_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ-1:0]      req_ready;
    logic [AW-1:0]         rom_addr;
    logic [DW-1:0]         rom_data;
    logic [N_REQ-1:0]      rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic [N_REQ-1:0]      starve;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    bg_rom_arbiter #(
        .N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .starve(starve)
    );

    // ROM contents: address 17'h00123 holds 24'hf80504, others a mix of the address.
    function automatic logic [DW-1:0] rom_func(input logic [AW-1:0] a);
        logic [AW-1:0] x;
        x = a ^ 17'h00123;
        return 24'hf80504 ^ {7'd0, x} ^ {x, 7'd0};
    endfunction

    // With ROM_LAT=1 the data for the registered address is valid one cycle later,
    // i.e. at the edge where the arbiter samples it.
    assign rom_data = rom_func(rom_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        longint        due;
    } rsp_t;

    rsp_t            rsp_q[$];
    int              m_wait [N_REQ];
    int              m_ptr;
    logic [AW-1:0]   m_rom_addr;
    logic [DW-1:0]   m_last_data;
    longint          m_cyc = 0;
    int              n_acc = 0;
    int              n_rsp_dut = 0;

    int              g;
    logic [N_REQ-1:0] e_rdy, e_stv, e_rv;
    logic [DW-1:0]   e_dat;
    logic [AW-1:0]   g_addr;
    rsp_t            r_item;

    function automatic int model_grant(input logic [N_REQ-1:0] v);
        for (int i = 1; i < N_REQ; i++)
            if (v[i] && m_wait[i] == MAX_WAIT) return i;
        if (v[0]) return 0;
        for (int k = m_ptr; k < N_REQ; k++)
            if (v[k]) return k;
        for (int k = 1; k < m_ptr; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
        m_ptr       = 1;
        m_rom_addr  = '0;
        m_last_data = '0;
        n_acc       = n_acc - rsp_q.size();
        rsp_q.delete();
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            chk("rst_rom_addr",  64'(rom_addr),  64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_data",  64'(rsp_data),  64'd0);
            chk("rst_starve",    64'(starve),    64'd0);
            model_reset();
        end else begin
            g = model_grant(req_valid);
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_stv = '0;
            for (int i = 1; i < N_REQ; i++) e_stv[i] = (m_wait[i] == MAX_WAIT);
            e_rv  = '0;
            e_dat = m_last_data;
            if (rsp_q.size() > 0 && rsp_q[0].due == m_cyc) begin
                r_item = rsp_q.pop_front();
                e_rv[r_item.port] = 1'b1;
                e_dat = rom_func(r_item.addr);
                m_last_data = e_dat;
            end
            chk("mon_ready",     64'(req_ready), 64'(e_rdy));
            chk("mon_starve",    64'(starve),    64'(e_stv));
            chk("mon_rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("mon_rsp_data",  64'(rsp_data),  64'(e_dat));
            chk("mon_rom_addr",  64'(rom_addr),  64'(m_rom_addr));
            if (rsp_valid != '0) n_rsp_dut++;
            for (int i = 1; i < N_REQ; i++) begin
                if (!req_valid[i] || g == i) m_wait[i] = 0;
                else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
            end
            if (g >= 0) begin
                g_addr = req_addr[g*AW +: AW];
                rsp_q.push_back('{port: g, addr: g_addr, due: m_cyc + 1 + ROM_LAT});
                m_rom_addr = g_addr;
                n_acc++;
                if (g >= 1) m_ptr = (g == N_REQ - 1) ? 1 : g + 1;
            end
            m_cyc++;
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step(input logic [N_REQ-1:0] v, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(posedge Clk);
        #1;
        req_valid = v;
        req_addr  = {a2, a1, a0};
        @(negedge Clk);
        #1;
    endtask

    logic [N_REQ-1:0] exp_pr [7];
    logic [N_REQ-1:0] rv;
    logic [N_REQ-1:0] rdy_prev;
    logic [AW-1:0]    ra [N_REQ];
    logic [AW-1:0]    sa;
    int               starve_cnt;

    initial begin
        Reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(negedge Clk);
        #2;
        Reset_n = 1'b1;

        // Latency: port 0 reads 17'h00123.
        step(3'b001, 17'h00123, 17'h0, 17'h0);
        chk("lat_ready", 64'(req_ready), 64'h1);
        step(3'b000, 17'h0, 17'h0, 17'h0);
        chk("lat_rsp_early", 64'(rsp_valid), 64'h0);
        step(3'b000, 17'h0, 17'h0, 17'h0);
        chk("lat_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("lat_rsp_data",  64'(rsp_data),  64'hf80504);

        // Priority then round-robin: 0,0,0,1,2,1,2.
        exp_pr = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
        for (int i = 0; i < 7; i++) begin
            step((i < 3) ? 3'b111 : 3'b110, 17'h0000a, 17'h0000b, 17'h0000c);
            chk("prio_grant", 64'(req_ready), 64'(exp_pr[i]));
        end
        repeat (3) step(3'b000, 17'h0, 17'h0, 17'h0);

        // Starvation: port 1 must win on the 16th cycle only.
        starve_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(3'b011, AW'(32'h200 + i), 17'h1aaaa, 17'h0);
            chk("starve_grant", 64'(req_ready), (i == 15) ? 64'h2 : 64'h1);
            chk("starve_flag",  64'(starve[1]), (i == 15) ? 64'h1 : 64'h0);
            starve_cnt += int'(starve[1]);
        end
        chk("starve_count", 64'(starve_cnt), 64'd1);
        repeat (4) step(3'b000, 17'h0, 17'h0, 17'h0);

        // Back-to-back: grants 1,2,1,2 with addresses 0..3, no bubbles.
        for (int s = 0; s < 6; s++) begin
            sa = AW'(s);
            if (s < 4) begin
                rv = (s % 2 == 0) ? 3'b010 : 3'b100;
                step(rv, 17'h0, sa, sa);
                chk("b2b_grant", 64'(req_ready), 64'(rv));
            end else begin
                step(3'b000, 17'h0, 17'h0, 17'h0);
            end
            if (s >= 2) begin
                sa = AW'(s - 2);
                chk("b2b_rsp_valid", 64'(rsp_valid), (s % 2 == 0) ? 64'h2 : 64'h4);
                chk("b2b_rsp_data",  64'(rsp_data),  64'(rom_func(sa)));
            end
        end
        repeat (3) step(3'b000, 17'h0, 17'h0, 17'h0);

        // Reset with two reads in flight.
        step(3'b001, 17'h00055, 17'h0, 17'h0);
        step(3'b001, 17'h00066, 17'h0, 17'h0);
        @(posedge Clk);
        #1;
        Reset_n   = 1'b0;
        req_valid = '0;
        @(negedge Clk);
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 17'h0, 17'h0, 17'h0);
            chk("rst_no_rsp",   64'(rsp_valid), 64'h0);
            chk("rst_addr_low", 64'(rom_addr),  64'h0);
        end
        step(3'b001, 17'h00077, 17'h0, 17'h0);
        chk("rst_ready_p0", 64'(req_ready), 64'h1);
        repeat (3) step(3'b000, 17'h0, 17'h0, 17'h0);

        // Random traffic; a waiting requester keeps valid and address stable.
        rv       = '0;
        rdy_prev = '0;
        for (int p = 0; p < N_REQ; p++) ra[p] = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int p = 0; p < N_REQ; p++) begin
                if (!(rv[p] && !rdy_prev[p])) begin
                    rv[p] = (p == 0) ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
                    ra[p] = AW'($urandom);
                end
            end
            step(rv, ra[0], ra[1], ra[2]);
            rdy_prev = req_ready;
        end
        repeat (6) step(3'b000, 17'h0, 17'h0, 17'h0);
        chk("rand_rsp_count", 64'(n_rsp_dut), 64'(n_acc));
        chk("rand_queue_empty", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
